// File: rtl/lector_banco_registros.sv
// lector_banco_registros
//
// Walks a register bank two registers at a time and sends every register
// out as a ready/valid stream. The stream ends with one extra word that
// holds the modulo-2^ANCHO sum of all registers. Each pair is read once,
// during LEER, and captured locally. Later bank writes therefore cannot
// change words that have already been read.
//
// Ports
//   Reloj        clock, rising edge
//   Reiniciar    synchronous reset, active low
//   Iniciar      start request (only looked at while idle)
//   Cancelar     abort a running scan
//   RtaA, RtaB   read data from the bank's two combinational read ports
//   DireccionA/B bank read addresses (even / odd register of the pair)
//   Dato         stream word
//   Indice       register index of Dato (0 for the checksum word)
//   EsSuma       Dato is the checksum word
//   Valido       stream word valid
//   Listo        consumer ready; a word moves on Valido & Listo
//   Ocupado      scan in progress
//   Hecho        one-cycle pulse after the checksum has been taken
module lector_banco_registros #(
    parameter int ANCHO       = 16,
    parameter int PROFUNDIDAD = 8
) (
    input  logic                           Reloj,
    input  logic                           Reiniciar,
    input  logic                           Iniciar,
    input  logic                           Cancelar,
    input  logic [ANCHO-1:0]               RtaA,
    input  logic [ANCHO-1:0]               RtaB,
    output logic [$clog2(PROFUNDIDAD)-1:0] DireccionA,
    output logic [$clog2(PROFUNDIDAD)-1:0] DireccionB,
    output logic [ANCHO-1:0]               Dato,
    output logic [$clog2(PROFUNDIDAD)-1:0] Indice,
    output logic                           EsSuma,
    output logic                           Valido,
    input  logic                           Listo,
    output logic                           Ocupado,
    output logic                           Hecho
);

    localparam int AW    = $clog2(PROFUNDIDAD);
    localparam int PARES = PROFUNDIDAD / 2;

    typedef enum logic [2:0] {
        INACTIVO,
        LEER,
        EMITIR_A,
        EMITIR_B,
        ENTREGAR_SUMA
    } estado_t;

    estado_t           estado;
    logic [AW-1:0]     k;
    logic [AW-1:0]     k_sig;
    logic [ANCHO-1:0]  suma;
    logic [ANCHO-1:0]  buf_a;
    logic [ANCHO-1:0]  buf_b;

    // The checksum wraps. Carries out of the top bit are dropped on purpose.
    function automatic logic [ANCHO-1:0] sumar_mod(input logic [ANCHO-1:0] a,
                                                   input logic [ANCHO-1:0] b);
        return a + b;
    endfunction

    assign k_sig   = k + AW'(1);
    assign Ocupado = (estado != INACTIVO);

    always_ff @(posedge Reloj) begin
        if (!Reiniciar) begin
            estado     <= INACTIVO;
            k          <= '0;
            suma       <= '0;
            buf_a      <= '0;
            buf_b      <= '0;
            Valido     <= 1'b0;
            Hecho      <= 1'b0;
            Dato       <= '0;
            Indice     <= '0;
            EsSuma     <= 1'b0;
            DireccionA <= '0;
            DireccionB <= AW'(1);
        end else begin
            Hecho <= 1'b0;
            if (estado != INACTIVO && Cancelar) begin
                // An abort wins over a transfer in the same cycle. The
                // pending word is dropped and suma is left as it was.
                estado     <= INACTIVO;
                Valido     <= 1'b0;
                EsSuma     <= 1'b0;
                Indice     <= '0;
                DireccionA <= '0;
                DireccionB <= AW'(1);
            end else begin
                case (estado)
                    INACTIVO: begin
                        if (Iniciar) begin
                            k          <= '0;
                            suma       <= '0;
                            DireccionA <= '0;
                            DireccionB <= AW'(1);
                            estado     <= LEER;
                        end
                    end
                    LEER: begin
                        // The addresses have been stable all cycle, so the
                        // read ports already hold this pair.
                        buf_a  <= RtaA;
                        buf_b  <= RtaB;
                        Dato   <= RtaA;
                        Indice <= DireccionA;
                        EsSuma <= 1'b0;
                        Valido <= 1'b1;
                        estado <= EMITIR_A;
                    end
                    EMITIR_A: begin
                        if (Listo) begin
                            suma   <= sumar_mod(suma, buf_a);
                            Dato   <= buf_b;
                            Indice <= DireccionB;
                            estado <= EMITIR_B;
                        end
                    end
                    EMITIR_B: begin
                        if (Listo) begin
                            suma <= sumar_mod(suma, buf_b);
                            if (k == AW'(PARES - 1)) begin
                                Dato   <= sumar_mod(suma, buf_b);
                                Indice <= '0;
                                EsSuma <= 1'b1;
                                estado <= ENTREGAR_SUMA;
                            end else begin
                                k          <= k_sig;
                                DireccionA <= k_sig << 1;
                                DireccionB <= (k_sig << 1) | AW'(1);
                                Valido     <= 1'b0;
                                estado     <= LEER;
                            end
                        end
                    end
                    ENTREGAR_SUMA: begin
                        if (Listo) begin
                            Valido     <= 1'b0;
                            EsSuma     <= 1'b0;
                            Hecho      <= 1'b1;
                            DireccionA <= '0;
                            DireccionB <= AW'(1);
                            estado     <= INACTIVO;
                        end
                    end
                    default: begin
                        estado <= INACTIVO;
                        Valido <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lector_banco_registros.sv
// Self-checking bench for lector_banco_registros.
// The bank is an array that the bench owns and reads combinationally.
// The expected stream comes from a snapshot of the bank taken when a scan
// starts: the registers in order, followed by their sum modulo 2^16.
module tb_lector_banco_registros;

    localparam int PROF = 8;

    logic        Reloj = 1'b0;
    logic        Reiniciar, Iniciar, Cancelar, Listo;
    logic [15:0] RtaA, RtaB, Dato;
    logic [2:0]  DireccionA, DireccionB, Indice;
    logic        EsSuma, Valido, Ocupado, Hecho;
    logic [15:0] bank [PROF];

    int checks = 0;
    int errors = 0;

    always #5 Reloj = ~Reloj;

    assign RtaA = bank[DireccionA];
    assign RtaB = bank[DireccionB];

    lector_banco_registros #(.ANCHO(16), .PROFUNDIDAD(PROF)) dut (
        .Reloj(Reloj), .Reiniciar(Reiniciar), .Iniciar(Iniciar), .Cancelar(Cancelar),
        .RtaA(RtaA), .RtaB(RtaB), .DireccionA(DireccionA), .DireccionB(DireccionB),
        .Dato(Dato), .Indice(Indice), .EsSuma(EsSuma), .Valido(Valido),
        .Listo(Listo), .Ocupado(Ocupado), .Hecho(Hecho)
    );

    typedef struct {
        logic [15:0] base;
        logic [15:0] paso;
        int          modo;   // 0: Listo always 1, 1: toggling, 2: random
        logic [15:0] suma;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge Reloj);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valido"}, Valido, 0);
        chk({tag, "_hecho"}, Hecho, 0);
        chk({tag, "_ocupado"}, Ocupado, 0);
        chk({tag, "_dato"}, Dato, 0);
        chk({tag, "_indice"}, Indice, 0);
        chk({tag, "_essuma"}, EsSuma, 0);
        chk({tag, "_dirA"}, DireccionA, 0);
        chk({tag, "_dirB"}, DireccionB, 1);
    endtask

    // Steps until the word at register idx is on the stream. Listo must be 1.
    task automatic esperar_indice(input logic [2:0] idx);
        bit ok;
        ok = 0;
        for (int c = 0; c < 100; c++) begin
            if (Valido && !EsSuma && Indice == idx) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk("espera_indice", ok, 1);
    endtask

    // Runs one whole scan. Cycle numbering: the cycle in which Iniciar is
    // driven is cycle 0. With Listo held at 1, Valido should first appear in
    // cycle 2 and Hecho in cycle 14.
    task automatic run_scan(input int modo, input bit poke, input bit ruido,
                            input bit check_lat, output logic [15:0] suma_obs);
        logic [15:0] snap [PROF];
        int unsigned total;
        logic [15:0] exp_d;
        logic [2:0]  exp_i;
        logic        exp_s;
        logic [15:0] prev_d;
        logic [2:0]  prev_i;
        logic        prev_s;
        bit          prev_hold, tog;
        int          j, n, first_v, hecho_n;

        total = 0;
        for (int i = 0; i < PROF; i++) begin
            snap[i] = bank[i];
            total += bank[i];
        end
        j = 0; first_v = -1; hecho_n = -1; prev_hold = 0; tog = 1;
        prev_d = '0; prev_i = '0; prev_s = 0;
        suma_obs = 'x;
        Iniciar = 1; Cancelar = 0; Listo = 1;
        tick();
        Iniciar = 0;
        n = 1;
        while (n < 400) begin
            if (poke && n == 2) bank[1] = 16'hAAAA;
            if (prev_hold) begin
                chk("hold_valido", Valido, 1);
                chk("hold_word", {Dato, Indice, EsSuma}, {prev_d, prev_i, prev_s});
            end
            if (Valido && first_v < 0) first_v = n;
            if (Hecho) begin
                hecho_n = n;
                break;
            end
            case (modo)
                0:       Listo = 1;
                1:       begin Listo = tog; tog = ~tog; end
                default: Listo = 1'($urandom_range(0, 1));
            endcase
            if (ruido) Iniciar = 1'($urandom_range(0, 1));
            if (Valido && Listo) begin
                if (j < PROF) begin
                    exp_d = snap[j]; exp_i = 3'(j); exp_s = 0;
                end else begin
                    exp_d = 16'(total); exp_i = 0; exp_s = 1;
                    suma_obs = Dato;
                end
                if (j > PROF) chk("palabra_extra", j, PROF);
                else chk("palabra", {Dato, Indice, EsSuma}, {exp_d, exp_i, exp_s});
                j++;
            end
            prev_hold = Valido && !Listo;
            prev_d = Dato; prev_i = Indice; prev_s = EsSuma;
            tick();
            n++;
        end
        Iniciar = 0;
        chk("num_palabras", j, PROF + 1);
        chk("hecho_visto", hecho_n > 0, 1);
        if (check_lat) begin
            chk("latencia_valido", first_v, 2);
            chk("latencia_hecho", hecho_n, 14);
        end
        chk("ocupado_fin", Ocupado, 0);
        tick();
        chk("hecho_un_ciclo", Hecho, 0);
    endtask

    initial begin
        vec_t        vecs [5];
        logic [15:0] s;

        vecs[0] = '{base: 16'h0000, paso: 16'h0101, modo: 0, suma: 16'h1C1C};
        vecs[1] = '{base: 16'h0000, paso: 16'h0101, modo: 1, suma: 16'h1C1C};
        vecs[2] = '{base: 16'hFFFF, paso: 16'h0000, modo: 0, suma: 16'hFFF8};
        vecs[3] = '{base: 16'h1234, paso: 16'h1111, modo: 0, suma: 16'h6F7C};
        vecs[4] = '{base: 16'h8000, paso: 16'h8000, modo: 2, suma: 16'h0000};

        for (int i = 0; i < PROF; i++) bank[i] = '0;
        Reiniciar = 0; Iniciar = 1; Cancelar = 1; Listo = 1;
        tick();
        tick();
        check_reset_outputs("reset");
        Reiniciar = 1; Iniciar = 0; Cancelar = 0;
        tick();
        chk("reposo_ocupado", Ocupado, 0);

        // Table of full scans.
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < PROF; i++) bank[i] = 16'(vecs[v].base + vecs[v].paso * i);
            run_scan(vecs[v].modo, 0, 0, vecs[v].modo == 0, s);
            chk("tabla_suma", s, vecs[v].suma);
        end

        // A register rewritten after its pair was read still streams the old value.
        for (int i = 0; i < PROF; i++) bank[i] = 16'(16'h0101 * i);
        run_scan(0, 1, 0, 1, s);
        chk("poke_suma", s, 16'h1C1C);
        bank[1] = 16'h0101;

        // Abort while register 3 (second word of pair 1) is offered, with Listo high.
        Listo = 1; Iniciar = 1;
        tick();
        Iniciar = 0;
        esperar_indice(3'd3);
        Cancelar = 1;
        tick();
        Cancelar = 0;
        chk("cancel_valido", Valido, 0);
        chk("cancel_ocupado", Ocupado, 0);
        for (int c = 0; c < 3; c++) begin
            chk("cancel_sin_hecho", Hecho, 0);
            tick();
        end
        run_scan(0, 0, 0, 1, s);
        chk("tras_cancel_suma", s, 16'h1C1C);

        // When idle, Cancelar has no effect and a start in the same cycle is honoured.
        Iniciar = 1; Cancelar = 1;
        tick();
        Iniciar = 0; Cancelar = 0;
        chk("inicia_con_cancel", Ocupado, 1);
        Cancelar = 1;
        tick();
        Cancelar = 0;
        chk("cancel_en_leer", Ocupado, 0);

        // Reset in the middle of pair 2.
        Listo = 1; Iniciar = 1;
        tick();
        Iniciar = 0;
        esperar_indice(3'd4);
        Reiniciar = 0; Iniciar = 1; Cancelar = 1;
        tick();
        check_reset_outputs("reset_medio");
        Reiniciar = 1; Iniciar = 0; Cancelar = 0;
        tick();
        run_scan(0, 0, 0, 1, s);
        chk("tras_reset_suma", s, 16'h1C1C);

        // Random banks and random consumer stalls. Iniciar is also pulsed
        // during each scan and must be ignored.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < PROF; i++) bank[i] = 16'($urandom);
            run_scan(2, 0, 1, 0, s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
